id_ex_operand_stage: RTL and testbench

//  Decode/execute boundary stage directly upstream of the ALU. Holds the 32x64 register file.

---
 rtl/alu_stage_pkg.sv | 27 ++
 rtl/regfile_2r1w.sv | 77 +++++++
 rtl/id_ex_operand_stage.sv | 117 +++++++++++
 tb/tb_id_ex_operand_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_stage_pkg
//  Description : Shared constants for the decode/execute operand stage:
//                default operand/index widths, ALU operation encodings and
//                the zero-register index.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_stage_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    // ALU operation encodings driven on ALUCtrl. Other codes pass through
    // the stage untouched; the ALU gives them meaning.
    localparam logic [3:0] ALU_AND   = 4'h0;
    localparam logic [3:0] ALU_OR    = 4'h1;
    localparam logic [3:0] ALU_ADD   = 4'h2;
    localparam logic [3:0] ALU_SUB   = 4'h6;
    localparam logic [3:0] ALU_PASSB = 4'h7;

    // X31 reads as zero and ignores writes.
    localparam logic [4:0] XZR_IDX = 5'd31;

endpackage : alu_stage_pkg
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_2r1w
//  Description : Register file with two asynchronous read ports and one
//                synchronous write port. Index NREGS-1 is the zero register:
//                it reads as 0 and writes to it are discarded, so it has no
//                storage.
//                Optional feature macro: REGFILE_WB_BYPASS_EN -- when
//                defined, a read that matches the write issued in the same
//                cycle returns the write data instead of the stored value.
//  Ports       : CLK, Reset_L        clock / async active-low reset
//                i_rdAddrA/B         read indices
//                o_rdDataA/B         read data (combinational)
//                i_wrEn/Addr/Data    write port, committed on posedge
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_2r1w #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic [ADDR_W-1:0] i_rdAddrA,
    input  logic [ADDR_W-1:0] i_rdAddrB,
    output logic [DATA_W-1:0] o_rdDataA,
    output logic [DATA_W-1:0] o_rdDataB,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData
);

    localparam logic [ADDR_W-1:0] c_XZR_IDX = ADDR_W'(NREGS - 1);

    // Only the architected, writable registers get storage.
    logic [DATA_W-1:0] r_regs [NREGS-1];

    logic w_wrHit;
    logic w_bypA;
    logic w_bypB;

    assign w_wrHit = i_wrEn && (i_wrAddr != c_XZR_IDX);

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            for (int i = 0; i < NREGS - 1; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wrHit) begin
            r_regs[i_wrAddr] <= i_wrData;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Forward the in-flight writeback so a same-cycle reader sees it without
    // a hazard bubble. w_wrHit already excludes the zero register.
    assign w_bypA = w_wrHit && (i_wrAddr == i_rdAddrA);
    assign w_bypB = w_wrHit && (i_wrAddr == i_rdAddrB);
`else
    // Readers see the pre-write value; the hazard unit inserts a bubble.
    assign w_bypA = 1'b0;
    assign w_bypB = 1'b0;
`endif

    always_comb begin
        o_rdDataA = '0;
        o_rdDataB = '0;
        if (i_rdAddrA != c_XZR_IDX) begin
            o_rdDataA = w_bypA ? i_wrData : r_regs[i_rdAddrA];
        end
        if (i_rdAddrB != c_XZR_IDX) begin
            o_rdDataB = w_bypB ? i_wrData : r_regs[i_rdAddrB];
        end
    end

endmodule : regfile_2r1w
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_operand_stage
//  Description : Decode/execute boundary stage in front of the ALU. Reads two
//                source registers, selects register or immediate for operand
//                B, and holds the result in a valid/ready ID/EX register.
//                Writeback from the end of the pipe enters through wb_*.
//                Optional feature macro: REGFILE_WB_BYPASS_EN -- same-cycle
//                writeback is forwarded into a capturing operand read.
//  Ports       : CLK, Reset_L              clock / async active-low reset
//                in_valid, in_ready        decode-side handshake
//                RegA, RegB, Imm, UseImm   operand sources
//                ALUCtrlIn, DstIn          operation / destination
//                flush                     squash the held instruction
//                out_valid, out_ready      EX-side handshake
//                BusA, BusB, ALUCtrl, DstOut  registered ALU inputs
//                wb_en, wb_reg, wb_data    register file writeback
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage
    import alu_stage_pkg::*;
#(
    parameter int DATA_W = alu_stage_pkg::DATA_W,
    parameter int ADDR_W = alu_stage_pkg::ADDR_W,
    parameter int NREGS  = alu_stage_pkg::NREGS
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] RegA,
    input  logic [ADDR_W-1:0] RegB,
    input  logic [DATA_W-1:0] Imm,
    input  logic              UseImm,
    input  logic [3:0]        ALUCtrlIn,
    input  logic [ADDR_W-1:0] DstIn,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] BusA,
    output logic [DATA_W-1:0] BusB,
    output logic [3:0]        ALUCtrl,
    output logic [ADDR_W-1:0] DstOut,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data
);

    localparam logic [ADDR_W-1:0] c_XZR_IDX = ADDR_W'(NREGS - 1);

    logic [DATA_W-1:0] w_rdA;
    logic [DATA_W-1:0] w_rdB;
    logic [DATA_W-1:0] w_opB;
    logic              w_capture;

    logic              r_outValid;
    logic [DATA_W-1:0] r_busA;
    logic [DATA_W-1:0] r_busB;
    logic [3:0]        r_aluCtrl;
    logic [ADDR_W-1:0] r_dst;

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .CLK       (CLK),
        .Reset_L   (Reset_L),
        .i_rdAddrA (RegA),
        .i_rdAddrB (RegB),
        .o_rdDataA (w_rdA),
        .o_rdDataB (w_rdB),
        .i_wrEn    (wb_en),
        .i_wrAddr  (wb_reg),
        .i_wrData  (wb_data)
    );

    assign w_opB = UseImm ? Imm : w_rdB;

    // Ready depends only on the output side, never on in_valid, so decode
    // can use it without a combinational loop.
    assign in_ready  = !r_outValid || out_ready;
    assign w_capture = in_valid && in_ready;

    // Flush outranks capture: the squashed slot carries XZR as destination
    // so nothing downstream can mistake it for a real write. Operand/control
    // registers only load on capture, which freezes them through stalls
    // regardless of later writebacks.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_outValid <= 1'b0;
            r_busA     <= '0;
            r_busB     <= '0;
            r_aluCtrl  <= '0;
            r_dst      <= '0;
        end else if (flush) begin
            r_outValid <= 1'b0;
            r_dst      <= c_XZR_IDX;
        end else if (w_capture) begin
            r_outValid <= 1'b1;
            r_busA     <= w_rdA;
            r_busB     <= w_opB;
            r_aluCtrl  <= ALUCtrlIn;
            r_dst      <= DstIn;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign out_valid = r_outValid;
    assign BusA      = r_busA;
    assign BusB      = r_busB;
    assign ALUCtrl   = r_aluCtrl;
    assign DstOut    = r_dst;

endmodule : id_ex_operand_stage
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_operand_stage
//  Description : Self-checking bench for id_ex_operand_stage. Directed cases
//                for reset, register read/write, XZR/immediate, same-cycle
//                writeback, stall freezing and flush, then randomized traffic
//                against a behavioural model of the stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  RegA, RegB, DstIn, DstOut, wb_reg;
    logic [63:0] Imm, BusA, BusB, wb_data;
    logic        UseImm, flush, out_valid, out_ready, wb_en;
    logic [3:0]  ALUCtrlIn, ALUCtrl;

    int total = 0;
    int bad   = 0;

    // Behavioural model of the architectural state.
    logic [63:0] mRegs [32];
    logic        mValid;
    logic [63:0] mA, mB;
    logic [3:0]  mCtrl;
    logic [4:0]  mDst;

    id_ex_operand_stage dut (
        .CLK       (CLK),
        .Reset_L   (Reset_L),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .RegA      (RegA),
        .RegB      (RegB),
        .Imm       (Imm),
        .UseImm    (UseImm),
        .ALUCtrlIn (ALUCtrlIn),
        .DstIn     (DstIn),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .BusA      (BusA),
        .BusB      (BusB),
        .ALUCtrl   (ALUCtrl),
        .DstOut    (DstOut),
        .wb_en     (wb_en),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data)
    );

    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] modelRead(input logic [4:0] idx);
        if (idx == 5'd31) return 64'd0;
`ifdef REGFILE_WB_BYPASS_EN
        if (wb_en && wb_reg == idx) return wb_data;
`endif
        return mRegs[idx];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mRegs[i] = 64'd0;
        mValid = 1'b0; mA = 0; mB = 0; mCtrl = 0; mDst = 0;
    endtask

    task automatic idle();
        in_valid = 0; RegA = 0; RegB = 0; Imm = 0; UseImm = 0; ALUCtrlIn = 0;
        DstIn = 0; flush = 0; out_ready = 1; wb_en = 0; wb_reg = 0; wb_data = 0;
    endtask

    task automatic checkAll(input string tag);
        checkVal({tag, ".valid"}, {63'd0, out_valid}, {63'd0, mValid});
        checkVal({tag, ".dst"}, {59'd0, DstOut}, {59'd0, mDst});
        if (mValid) begin
            checkVal({tag, ".busA"}, BusA, mA);
            checkVal({tag, ".busB"}, BusB, mB);
            checkVal({tag, ".ctrl"}, {60'd0, ALUCtrl}, {60'd0, mCtrl});
        end
    endtask

    // One clock: checks in_ready against the model, predicts the next state
    // from the current inputs, and lands 1 ns after the rising edge.
    task automatic tick();
        logic rdy, cap;
        logic [63:0] a, b;
        #1;
        rdy = !mValid || out_ready;
        checkVal("in_ready", {63'd0, in_ready}, {63'd0, rdy});
        cap = in_valid && rdy;
        a = modelRead(RegA);
        b = UseImm ? Imm : modelRead(RegB);
        @(posedge CLK);
        if (flush) begin
            mValid = 0; mDst = 5'd31;
        end else if (cap) begin
            mValid = 1; mA = a; mB = b; mCtrl = ALUCtrlIn; mDst = DstIn;
        end else if (out_ready) begin
            mValid = 0;
        end
        if (wb_en && wb_reg != 5'd31) mRegs[wb_reg] = wb_data;
        #1;
    endtask

    task automatic writeReg(input logic [4:0] r, input logic [63:0] d);
        idle(); wb_en = 1; wb_reg = r; wb_data = d;
        tick(); idle();
    endtask

    initial begin
        idle();
        modelReset();
        Reset_L = 0;
        repeat (2) @(posedge CLK);
        #1 Reset_L = 1;
        checkAll("reset");
        checkVal("reset.busA", BusA, 64'd0);

        // 1. Reset while stalled; X5 must read 0 afterwards.
        writeReg(5'd5, 64'h55);
        in_valid = 1; RegA = 5; out_ready = 0; tick();
        idle(); out_ready = 0; tick();
        checkVal("t1.prevalid", {63'd0, out_valid}, 64'd1);
        #2 Reset_L = 0; modelReset();
        #1;
        checkVal("t1.valid", {63'd0, out_valid}, 64'd0);
        checkVal("t1.busA", BusA, 64'd0);
        checkVal("t1.busB", BusB, 64'd0);
        @(negedge CLK); Reset_L = 1;
        @(posedge CLK); #1;
        idle(); in_valid = 1; RegA = 5; tick(); idle();
        checkVal("t1.x5", BusA, 64'd0);

        // 2. Write then read.
        writeReg(5'd3, 64'h21389);
        in_valid = 1; RegA = 3; RegB = 3; ALUCtrlIn = 4'h0; tick(); idle();
        checkVal("t2.busA", BusA, 64'h21389);
        checkVal("t2.busB", BusB, 64'h21389);
        checkVal("t2.ctrl", {60'd0, ALUCtrl}, 64'd0);
        checkVal("t2.valid", {63'd0, out_valid}, 64'd1);

        // 3. XZR and immediate.
        writeReg(5'd31, 64'hFFFF);
        in_valid = 1; RegA = 31; UseImm = 1; Imm = 64'h4500; ALUCtrlIn = 4'h2; tick(); idle();
        checkVal("t3.busA", BusA, 64'd0);
        checkVal("t3.busB", BusB, 64'h4500);
        checkVal("t3.ctrl", {60'd0, ALUCtrl}, 64'd2);

        // 4. Same-cycle writeback and capture of X7.
        in_valid = 1; RegA = 7; wb_en = 1; wb_reg = 7; wb_data = 64'h9231; tick(); idle();
`ifdef REGFILE_WB_BYPASS_EN
        checkVal("t4.busA", BusA, 64'h9231);
`else
        checkVal("t4.busA", BusA, 64'd0);
`endif

        // 5. Stall then writeback to the frozen source.
        writeReg(5'd4, 64'd1);
        in_valid = 1; RegA = 4; DstIn = 5'd9; tick(); idle();
        for (int i = 0; i < 3; i++) begin
            out_ready = 0; in_valid = 1; RegA = 2; DstIn = 5'd10;
            wb_en = (i == 1); wb_reg = 4; wb_data = 64'd2;
            #1 checkVal("t5.in_ready", {63'd0, in_ready}, 64'd0);
            tick();
            checkVal("t5.busA", BusA, 64'd1);
            checkVal("t5.dst", {59'd0, DstOut}, 64'd9);
        end
        idle(); in_valid = 1; RegA = 4; DstIn = 5'd10; out_ready = 1; tick(); idle();
        checkVal("t5.accept", {59'd0, DstOut}, 64'd10);
        checkVal("t5.newA", BusA, 64'd2);

        // 6. Flush beats capture.
        in_valid = 1; RegA = 3; DstIn = 5'd12; flush = 1;
        #1 checkVal("t6.in_ready", {63'd0, in_ready}, 64'd1);
        tick(); idle();
        checkVal("t6.valid", {63'd0, out_valid}, 64'd0);
        checkVal("t6.dst", {59'd0, DstOut}, 64'd31);
        tick();
        checkVal("t6.stay", {63'd0, out_valid}, 64'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            RegA      = 5'($urandom_range(0, 31));
            RegB      = 5'($urandom_range(0, 31));
            Imm       = {$urandom, $urandom};
            UseImm    = $urandom_range(0, 1) == 1;
            ALUCtrlIn = 4'($urandom_range(0, 15));
            DstIn     = 5'($urandom_range(0, 31));
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            wb_en     = $urandom_range(0, 1) == 1;
            wb_reg    = ($urandom_range(0, 1) == 1) ? RegA : 5'($urandom_range(0, 31));
            wb_data   = {$urandom, $urandom};
            tick();
            checkAll("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_id_ex_operand_stage
`default_nettype wire
